// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin arbiter sharing one seconds timer among N_REQ requesters
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset          asynchronous active-low reset; release is synchronised internally
//   req_i          per-requester level request, held until that requester's done_o
//   req_seconds_i  packed 32-bit durations, slice k = bits [32k+31:32k]
//   grant_o        one-hot current owner of the timer, zero when idle
//   done_o         one-hot single-cycle completion pulse to the owner
//   busy_o         high whenever an owner holds the timer
//   timer_we_o     one-cycle start strobe to the timer
//   timer_wdata_o  duration written to the timer, held until the next grant
//   timer_done_i   timer completion level (registered, cleared by a start)
module timer_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [32*N_REQ-1:0]  req_seconds_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic [N_REQ-1:0]     done_o,
  output logic                 busy_o,
  output logic                 timer_we_o,
  output logic [31:0]          timer_wdata_o,
  input  logic                 timer_done_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0] N_WRAP = (IDX_W+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   probe;
  logic             found;
  logic [31:0]      win_seconds;
  logic [31:0]      seconds_q;
  logic             armed;
  logic             dropped;
  logic [N_REQ-1:0] owner_oh;

  // Reset asserts immediately but releases two edges later, so the first
  // state change can only happen on the third rising edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    probe  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      probe = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (probe >= N_WRAP) begin
        probe = probe - N_WRAP;
      end
      if (!found && req_i[probe[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = probe[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_seconds = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == IDX_W'(k)) begin
        win_seconds = req_seconds_i[32*k +: 32];
      end
    end
  end

  // A completion only counts once the timer has been seen low after our
  // start; a level left high by a previous run must fall and rise again.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (found) state_nxt = START;
      START: state_nxt = (seconds_q == 32'd0) ? DONE : WAIT;
      WAIT: begin
        if (timer_done_i && armed) begin
          state_nxt = (dropped || !req_i[owner]) ? IDLE : DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      seconds_q <= '0;
      armed     <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        owner     <= winner;
        seconds_q <= win_seconds;
        rr_ptr    <= (winner == IDX_W'(N_REQ-1)) ? '0 : winner + IDX_W'(1);
        armed     <= 1'b0;
        dropped   <= 1'b0;
      end else begin
        if ((state == START || state == WAIT) && !timer_done_i) begin
          armed <= 1'b1;
        end
        // Withdrawal is sticky: the owner does not get done_o even if it
        // raises its request again before the timer finishes.
        if (state == WAIT && !req_i[owner]) begin
          dropped <= 1'b1;
        end
      end
    end
  end

  assign owner_oh      = N_REQ'(1) << owner;
  assign grant_o       = (state != IDLE) ? owner_oh : '0;
  assign done_o        = (state == DONE) ? owner_oh : '0;
  assign busy_o        = (state != IDLE);
  assign timer_we_o    = (state == START) && (seconds_q != 32'd0);
  assign timer_wdata_o = seconds_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - self-checking bench for timer_arbiter
module tb_timer_arbiter;

  localparam int N     = 4;
  localparam int SCALE = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [32*N-1:0] req_seconds_i = '0;
  logic [N-1:0]    grant_o;
  logic [N-1:0]    done_o;
  logic            busy_o;
  logic            timer_we_o;
  logic [31:0]     timer_wdata_o;
  logic            timer_done_i;

  int n_cmp = 0;
  int n_bad = 0;

  timer_arbiter #(.N_REQ(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req_i),
    .req_seconds_i (req_seconds_i),
    .grant_o       (grant_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .timer_we_o    (timer_we_o),
    .timer_wdata_o (timer_wdata_o),
    .timer_done_i  (timer_done_i)
  );

  always #5 clk = ~clk;

  // Timer: done rises seconds*SCALE+1 cycles after a start, cleared by start.
  logic tmr_done;
  int   tmr_cnt;
  logic tmr_run;
  logic ovr_en = 1'b0;
  logic ovr_val = 1'b0;
  assign timer_done_i = ovr_en ? ovr_val : tmr_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_done <= 1'b0;
      tmr_cnt  <= 0;
      tmr_run  <= 1'b0;
    end else if (timer_we_o) begin
      tmr_done <= 1'b0;
      tmr_cnt  <= int'(timer_wdata_o) * SCALE;
      tmr_run  <= 1'b1;
    end else if (tmr_run) begin
      if (tmr_cnt <= 1) begin
        tmr_done <= 1'b1;
        tmr_run  <= 1'b0;
      end else begin
        tmr_cnt <= tmr_cnt - 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Reference model: transaction-level view of arbitration and ownership.
  int           ref_ptr = 0;
  int           m_owner = 0;
  int           w;
  logic         is_new;
  logic [31:0]  exp_wdata = '0;
  logic [N-1:0] prev_req = '0;
  logic [N-1:0] prev_grant = '0;
  logic [32*N-1:0] prev_sec = '0;
  logic [N-1:0] last_done = '0;
  logic         mon_on = 1'b0;
  int           grant_log[$];
  int           done_log[$];
  int           gcnt[N];
  int           dcnt[N];

  initial begin
    forever begin
      @(negedge clk);
      last_done = done_o;
      if (!reset) begin
        ref_ptr   = 0;
        exp_wdata = '0;
        prev_grant = '0;
      end else if (mon_on) begin
        is_new = (grant_o != 0) && (prev_grant == 0);
        check_eq("busy_vs_grant", 32'(busy_o), 32'(grant_o != 0));
        if (is_new) begin
          w = rr_pick(prev_req, ref_ptr);
          check_eq("rr_winner", 32'(grant_o), (w < 0) ? 32'hdead : (32'(1) << w));
          if (w >= 0) begin
            exp_wdata = prev_sec[32*w +: 32];
            check_eq("start_we", 32'(timer_we_o), 32'(exp_wdata != 0));
            ref_ptr = (w + 1) % N;
            m_owner = w;
            gcnt[w]++;
            grant_log.push_back(w);
          end
        end else begin
          check_eq("we_outside_start", 32'(timer_we_o), 32'd0);
          if (prev_grant != 0 && grant_o != 0)
            check_eq("grant_stable", 32'(grant_o), 32'(prev_grant));
        end
        check_eq("wdata_hold", timer_wdata_o, exp_wdata);
        if (done_o != 0) begin
          check_eq("done_vs_grant", 32'(done_o), 32'(grant_o));
          check_eq("done_owner", 32'(done_o), 32'(1) << m_owner);
          dcnt[m_owner]++;
          done_log.push_back(m_owner);
        end
      end
      prev_req   = req_i;
      prev_sec   = req_seconds_i;
      prev_grant = grant_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_sec(input int k, input logic [31:0] v);
    req_seconds_i[32*k +: 32] = v;
  endtask

  task automatic wait_done(input int k, input string tag);
    int t;
    t = 0;
    while (done_o[k] !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    check_eq(tag, 32'(done_o), 32'(1) << k);
    req_i[k] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  int   t;
  int   c;
  int   total;
  logic saw_done;
  logic last_td;

  initial begin
    // Reset state
    #3;
    check_eq("rst_grant", 32'(grant_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_we", 32'(timer_we_o), 32'd0);
    check_eq("rst_wdata", timer_wdata_o, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    mon_on = 1'b1;

    // Single request, latency and duration
    req_i = 4'b0001;
    set_sec(0, 32'd3);
    check_eq("single_pre_grant", 32'(grant_o), 32'd0);
    tick();
    check_eq("single_grant", 32'(grant_o), 32'b0001);
    check_eq("single_we", 32'(timer_we_o), 32'd1);
    check_eq("single_wdata", timer_wdata_o, 32'd3);
    tick();
    check_eq("single_we_once", 32'(timer_we_o), 32'd0);
    check_eq("single_wait_grant", 32'(grant_o), 32'b0001);
    c = 1;
    while (done_o == 0 && c < 100) begin
      tick();
      c++;
    end
    check_eq("single_done_lat", 32'(c), 32'(3 * SCALE + 2));
    wait_done(0, "single_done");
    tick();
    check_eq("single_idle_busy", 32'(busy_o), 32'd0);
    check_eq("single_idle_grant", 32'(grant_o), 32'd0);

    // Zero duration
    req_i = 4'b0100;
    set_sec(2, 32'd0);
    tick();
    check_eq("zero_grant", 32'(grant_o), 32'b0100);
    check_eq("zero_no_we", 32'(timer_we_o), 32'd0);
    tick();
    check_eq("zero_done", 32'(done_o), 32'b0100);
    req_i = 4'b0000;
    tick();
    check_eq("zero_busy_low", 32'(busy_o), 32'd0);

    // Stale timer_done_i held high through the start
    ovr_en  = 1'b1;
    ovr_val = 1'b1;
    req_i   = 4'b0010;
    set_sec(1, 32'd1);
    tick();
    check_eq("stale_grant", 32'(grant_o), 32'b0010);
    saw_done = 1'b0;
    repeat (6) begin
      tick();
      if (done_o != 0 || !busy_o) saw_done = 1'b1;
    end
    check_eq("stale_held", 32'(saw_done), 32'd0);
    ovr_val = 1'b0;
    repeat (2) tick();
    ovr_val = 1'b1;
    wait_done(1, "stale_done");
    ovr_en = 1'b0;
    tick();

    // Reset mid-WAIT
    req_i = 4'b1000;
    set_sec(3, 32'd2);
    repeat (3) tick();
    check_eq("rmw_busy_before", 32'(busy_o), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rmw_grant", 32'(grant_o), 32'd0);
    check_eq("rmw_done", 32'(done_o), 32'd0);
    check_eq("rmw_busy", 32'(busy_o), 32'd0);
    check_eq("rmw_we", 32'(timer_we_o), 32'd0);
    check_eq("rmw_wdata", timer_wdata_o, 32'd0);
    req_i = 4'b1001;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_eq("rmw_sync_hold", 32'(grant_o), 32'd0);
    t = 0;
    while (grant_o == 0 && t < 10) begin
      tick();
      t++;
    end
    check_eq("rmw_first_grant", 32'(grant_o), 32'b0001);
    wait_done(0, "rmw_done0");
    wait_done(3, "rmw_done3");
    tick();

    // Owner withdrawal mid-WAIT
    req_i = 4'b1010;
    set_sec(1, 32'd2);
    set_sec(3, 32'd2);
    tick();
    check_eq("wd_grant", 32'(grant_o), 32'b0010);
    repeat (2) tick();
    req_i[1] = 1'b0;
    t = 0;
    saw_done = 1'b0;
    last_td = 1'b0;
    while (grant_o == 4'b0010 && t < 100) begin
      if (done_o != 0) saw_done = 1'b1;
      last_td = timer_done_i;
      tick();
      t++;
    end
    check_eq("wd_no_done", 32'(saw_done | (done_o != 0)), 32'd0);
    check_eq("wd_held_to_timer", 32'(last_td), 32'd1);
    t = 0;
    while (grant_o == 0 && t < 10) begin
      tick();
      t++;
    end
    check_eq("wd_next_grant", 32'(grant_o), 32'b1000);
    wait_done(3, "wd_done3");
    tick();

    // Full contention with wrap
    do_reset();
    grant_log.delete();
    done_log.delete();
    req_i = 4'b1111;
    for (int k = 0; k < N; k++) set_sec(k, 32'd1);
    t = 0;
    while (grant_log.size() < 5 && t < 400) begin
      tick();
      t++;
    end
    check_eq("cont_grants", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check_eq("cont_order", 32'((i < grant_log.size()) ? grant_log[i] : -1), 32'(i % N));
    check_eq("cont_dones", 32'(done_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("cont_done_order", 32'((i < done_log.size()) ? done_log[i] : -1), 32'(i));
    req_i = '0;
    t = 0;
    while (busy_o && t < 100) begin
      tick();
      t++;
    end
    check_eq("cont_drain", 32'(busy_o), 32'd0);

    // Randomised traffic
    for (int k = 0; k < N; k++) begin
      gcnt[k] = 0;
      dcnt[k] = 0;
    end
    repeat (2000) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (req_i[k] && last_done[k]) begin
          if ($urandom_range(9) < 7) req_i[k] = 1'b0;
        end else if (!req_i[k] && $urandom_range(7) == 0) begin
          req_i[k] = 1'b1;
          set_sec(k, 32'($urandom_range(3)));
        end
        if ($urandom_range(15) == 0) set_sec(k, 32'($urandom_range(3)));
      end
    end
    t = 0;
    while ((req_i != 0 || busy_o) && t < 1000) begin
      tick();
      for (int k = 0; k < N; k++)
        if (req_i[k] && last_done[k]) req_i[k] = 1'b0;
      t++;
    end
    check_eq("rand_drain", 32'(req_i != 0 || busy_o), 32'd0);
    total = 0;
    for (int k = 0; k < N; k++) begin
      check_eq("rand_done_per_grant", 32'(dcnt[k]), 32'(gcnt[k]));
      total += gcnt[k];
    end
    check_eq("rand_activity", 32'(total > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
